// File: rtl/hub75_apb_pkg.sv
// Shared definitions for the Hub75 APB responder and its boot-time loader:
// register map, byte addresses, status signature and loader FSM encoding.
package hub75_apb_pkg;

    localparam logic [15:0] REG_STATUS_W  = 16'h8000;
    localparam logic [15:0] REG_CONTROL_W = 16'h8001;
    localparam logic [15:0] REG_PPROW_W   = 16'h8002;

    localparam logic [17:0] ADDR_STATUS  = {REG_STATUS_W, 2'b00};
    localparam logic [17:0] ADDR_CONTROL = {REG_CONTROL_W, 2'b00};
    localparam logic [17:0] ADDR_PPROW   = {REG_PPROW_W, 2'b00};

    localparam logic [31:0] STATUS_SIG_DEFAULT = 32'hDEAD_BEEF;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE   = 3'd0;
    localparam fsm_state_t ST_W_CTRL = 3'd1;
    localparam fsm_state_t ST_W_PPR  = 3'd2;
    localparam fsm_state_t ST_FILL   = 3'd3;
    localparam fsm_state_t ST_R_STAT = 3'd4;
    localparam fsm_state_t ST_FIN    = 3'd5;

    // Frame-buffer byte address of one pixel word.
    function automatic logic [17:0] pixel_addr(input logic [5:0] row, input logic [8:0] col);
        return {1'b0, row, col, 2'b00};
    endfunction

endpackage

// File: rtl/hub75_pattern_gen.sv
// Test-pattern generator: maps a pixel position to a 32-bit ABGR word.
module hub75_pattern_gen
    import hub75_apb_pkg::*;
(
    input  logic [5:0]  row,
    input  logic [5:0]  col,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_colour,
    output logic [31:0] pixel
);

    logic [2:0] bar;
    logic [7:0] r, g, b;

    always_comb begin
        bar = col[5:3];
        r   = solid_colour[7:0];
        g   = solid_colour[15:8];
        b   = solid_colour[23:16];
        case (pattern_sel)
            2'd1: begin
                r = {8{bar[0]}};
                g = {8{bar[1]}};
                b = {8{bar[2]}};
            end
            2'd2: begin
                r = {col, 2'b00};
                g = {row, 2'b00};
                b = 8'h00;
            end
            default: ;
        endcase
        pixel = {8'hFF, b, g, r};
    end

endmodule

// File: rtl/apb_fb_loader.sv
// APB initiator that configures the Hub75 block, fills its frame buffer with
// a test pattern and checks the STATUS signature.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for start, bus idle
// ST_W_CTRL | writing CONTROL
// ST_W_PPR  | writing pixels-per-row
// ST_FILL   | writing pixel words, col inner / row outer
// ST_R_STAT | reading STATUS
// ST_FIN    | one-cycle done pulse, bus idle
module apb_fb_loader
    import hub75_apb_pkg::*;
#(
    parameter int          PPR        = 64,
    parameter int          ROWS       = 32,
    parameter logic [31:0] CTRL_INIT  = 32'h0000_0001,
    parameter logic [31:0] STATUS_SIG = STATUS_SIG_DEFAULT,
    parameter int          TIMEOUT    = 255
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        start,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_colour,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        err,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    output logic [17:0] m_paddr,
    output logic [31:0] m_pwdata,
    input  logic [31:0] m_prdata,
    input  logic        m_pready,
    input  logic        m_pslverr
);

    localparam logic [8:0] COL_LAST  = 9'(PPR - 1);
    localparam logic [5:0] ROW_LAST  = 6'(ROWS - 1);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    fsm_state_t  state;
    logic [7:0]  wait_cnt;
    logic [5:0]  row, nxt_row, gen_row;
    logic [8:0]  col, nxt_col;
    logic [5:0]  gen_col;
    logic        last_col, last_pix, abort;
    logic [31:0] pix_word;
    logic [17:0] setup_addr;
    logic [31:0] setup_data;
    logic        setup_write;

    always_comb begin
        last_col = (col == COL_LAST);
        last_pix = last_col && (row == ROW_LAST);
        nxt_col  = last_col ? 9'd0 : col + 9'd1;
        nxt_row  = last_col ? row + 6'd1 : row;
        gen_row  = (state == ST_FILL) ? nxt_row : 6'd0;
        gen_col  = (state == ST_FILL) ? nxt_col[5:0] : 6'd0;
        abort    = m_pready ? m_pslverr : (wait_cnt == WAIT_LAST);
    end

    hub75_pattern_gen u_pattern_gen (
        .row          (gen_row),
        .col          (gen_col),
        .pattern_sel  (pattern_sel),
        .solid_colour (solid_colour),
        .pixel        (pix_word)
    );

    // Address/data/direction for the SETUP that follows the current state.
    always_comb begin
        setup_write = 1'b1;
        setup_addr  = pixel_addr(nxt_row, nxt_col);
        setup_data  = pix_word;
        case (state)
            ST_IDLE: begin
                setup_addr = ADDR_CONTROL;
                setup_data = CTRL_INIT;
            end
            ST_W_CTRL: begin
                setup_addr = ADDR_PPROW;
                setup_data = 32'(PPR);
            end
            ST_W_PPR: setup_addr = pixel_addr(6'd0, 9'd0);
            ST_FILL: begin
                if (last_pix) begin
                    setup_write = 1'b0;
                    setup_addr  = ADDR_STATUS;
                    setup_data  = 32'h0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= ST_IDLE;
            wait_cnt  <= 8'd0;
            row       <= 6'd0;
            col       <= 9'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err       <= 1'b0;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_paddr   <= 18'd0;
            m_pwdata  <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_W_CTRL;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        err       <= 1'b0;
                        row       <= 6'd0;
                        col       <= 9'd0;
                        wait_cnt  <= 8'd0;
                        m_psel    <= 1'b1;
                        m_penable <= 1'b0;
                        m_pwrite  <= setup_write;
                        m_paddr   <= setup_addr;
                        m_pwdata  <= setup_data;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    if (!m_penable) begin
                        m_penable <= 1'b1;
                    end else if (abort) begin
                        state     <= ST_FIN;
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        pass      <= 1'b0;
                    end else if (m_pready && state == ST_R_STAT) begin
                        state     <= ST_FIN;
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (m_prdata == STATUS_SIG);
                    end else if (m_pready) begin
                        m_penable <= 1'b0;
                        m_pwrite  <= setup_write;
                        m_paddr   <= setup_addr;
                        m_pwdata  <= setup_data;
                        wait_cnt  <= 8'd0;
                        case (state)
                            ST_W_CTRL: state <= ST_W_PPR;
                            ST_W_PPR:  state <= ST_FILL;
                            ST_FILL: begin
                                col <= nxt_col;
                                row <= nxt_row;
                                if (last_pix) state <= ST_R_STAT;
                            end
                            default: ;
                        endcase
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_fb_loader.sv
// Bench for apb_fb_loader: APB responder model plus a transfer scoreboard.
module tb_apb_fb_loader;
    import hub75_apb_pkg::*;

    localparam int PPR  = 64;
    localparam int ROWS = 2;
    localparam int NXF  = 3 + PPR * ROWS;

    typedef struct packed {
        logic        write;
        logic [17:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic        pclk, presetn, start;
    logic [1:0]  pattern_sel;
    logic [23:0] solid_colour;
    logic        busy, done, pass, err;
    logic        m_psel, m_penable, m_pwrite;
    logic [17:0] m_paddr;
    logic [31:0] m_pwdata, m_prdata;
    logic        m_pready, m_pslverr;

    apb_fb_loader #(
        .PPR(PPR), .ROWS(ROWS), .CTRL_INIT(32'h1),
        .STATUS_SIG(32'hDEAD_BEEF), .TIMEOUT(255)
    ) dut (
        .pclk(pclk), .presetn(presetn), .start(start),
        .pattern_sel(pattern_sel), .solid_colour(solid_colour),
        .busy(busy), .done(done), .pass(pass), .err(err),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int    checks = 0;
    int    failures = 0;
    xfer_t exp_q[$];
    int    ws_cfg = 0, ws_cnt = 0;
    bit    stall_ppr = 0, slverr_ctrl = 0, sb_en = 1, prev_wait = 0;
    int    xfer_cnt = 0, stall_cycles = 0, stab_err = 0, unexp = 0;
    logic [50:0] hold_bus;
    logic [31:0] cap8, cap24, cap56;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pixel(input int r, input int c,
                                                input logic [1:0] sel, input logic [23:0] sc);
        logic [7:0] rr, gg, bb;
        int bar;
        bar = (c / 8) % 8;
        {bb, gg, rr} = sc;
        if (sel == 2'd1) begin
            rr = (bar % 2 == 1)       ? 8'hFF : 8'h00;
            gg = ((bar / 2) % 2 == 1) ? 8'hFF : 8'h00;
            bb = (bar >= 4)           ? 8'hFF : 8'h00;
        end else if (sel == 2'd2) begin
            rr = 8'((c % 64) * 4);
            gg = 8'((r % 64) * 4);
            bb = 8'h00;
        end
        return {8'hFF, bb, gg, rr};
    endfunction

    task automatic push_seq(input logic [1:0] sel, input logic [23:0] sc, input int n);
        xfer_t full[$];
        full.push_back({1'b1, 18'h20004, 32'h1});
        full.push_back({1'b1, 18'h20008, 32'(PPR)});
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < PPR; c++)
                full.push_back({1'b1, 18'(r * 2048 + c * 4), model_pixel(r, c, sel, sc)});
        full.push_back({1'b0, 18'h20000, 32'h0});
        for (int i = 0; i < n; i++) exp_q.push_back(full[i]);
    endtask

    // Responder and transfer monitor share one block so pready is settled before it is judged.
    always @(negedge pclk) begin
        if (!presetn) begin
            m_pready = 1'b0; m_pslverr = 1'b0; ws_cnt = 0; prev_wait = 0;
        end else if (m_psel && m_penable) begin
            if (prev_wait && ({m_pwrite, m_paddr, m_pwdata} != hold_bus)) stab_err++;
            m_pready  = (ws_cnt >= ws_cfg) && !(stall_ppr && m_paddr == 18'h20008);
            m_pslverr = m_pready && slverr_ctrl && (m_paddr == 18'h20004);
            ws_cnt++;
            hold_bus  = {m_pwrite, m_paddr, m_pwdata};
            prev_wait = !m_pready;
            if (!m_pready) begin
                stall_cycles++;
            end else if (sb_en) begin
                xfer_t o, e;
                xfer_cnt++;
                o = {m_pwrite, m_paddr, m_pwrite ? m_pwdata : 32'h0};
                if (m_paddr == 18'h00020) cap8  = m_pwdata;
                if (m_paddr == 18'h00060) cap24 = m_pwdata;
                if (m_paddr == 18'h000E0) cap56 = m_pwdata;
                if (exp_q.size() == 0) begin
                    unexp++;
                end else begin
                    e = exp_q.pop_front();
                    check_eq($sformatf("xfer%0d", xfer_cnt), 64'(o), 64'(e));
                end
            end
        end else begin
            m_pready = 1'b0; m_pslverr = 1'b0; ws_cnt = 0; prev_wait = 0;
        end
    end

    task automatic run_seq(input string nm, input int exp_lat, input bit exp_pass,
                           input bit exp_err, input int exp_xfers, input int inject_at);
        int lat;
        @(negedge pclk); #1;
        start = 1'b1;
        xfer_cnt = 0; stall_cycles = 0; stab_err = 0; unexp = 0;
        lat = 1;
        while (!done && lat < 2000) begin
            @(negedge pclk); #1;
            lat++;
            start = (inject_at != 0 && lat == inject_at);
            if (lat == 2)
                check_eq({nm, "_first_setup"}, 64'({m_psel, m_penable, busy, m_pwrite, m_paddr}),
                         64'({4'b1011, 18'h20004}));
        end
        start = 1'b0;
        check_eq({nm, "_done"}, 64'(done), 64'(1));
        check_eq({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        check_eq({nm, "_pass_err"}, 64'({pass, err}), 64'({exp_pass, exp_err}));
        check_eq({nm, "_bus_idle"}, 64'({m_psel, m_penable, busy}), 64'(3'b001));
        check_eq({nm, "_xfers"}, 64'(xfer_cnt), 64'(exp_xfers));
        check_eq({nm, "_leftover"}, 64'(exp_q.size() + unexp), 64'(0));
        check_eq({nm, "_stable"}, 64'(stab_err), 64'(0));
        @(negedge pclk); #1;
        check_eq({nm, "_done_1cyc"}, 64'({done, busy, pass, err}), 64'({2'b00, exp_pass, exp_err}));
        repeat (3) @(negedge pclk);
        #1;
        check_eq({nm, "_stays_idle"}, 64'({busy, m_psel}), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        int n;
        presetn = 1'b0; start = 1'b0; pattern_sel = 2'd0; solid_colour = 24'h0;
        m_prdata = 32'hDEAD_BEEF; m_pready = 1'b0; m_pslverr = 1'b0;
        repeat (3) @(negedge pclk);
        #1;
        check_eq("rst_ctl", 64'({m_psel, m_penable, m_pwrite, busy, done, pass, err}), 64'(0));
        check_eq("rst_addr_data", 64'({m_paddr, m_pwdata}), 64'(0));
        presetn = 1'b1;

        // Solid red, zero wait states.
        pattern_sel = 2'd0; solid_colour = 24'h0000FF;
        push_seq(2'd0, 24'h0000FF, NXF);
        run_seq("solid", 1 + 2 * NXF + 1, 1'b1, 1'b0, NXF, 0);

        // Colour bars, spot-checked at three columns.
        pattern_sel = 2'd1; cap8 = '0; cap24 = '0; cap56 = '0;
        push_seq(2'd1, 24'h0, NXF);
        run_seq("bars", 1 + 2 * NXF + 1, 1'b1, 1'b0, NXF, 0);
        check_eq("bars_col8", 64'(cap8), 64'(32'hFF0000FF));
        check_eq("bars_col24", 64'(cap24), 64'(32'hFF00FFFF));
        check_eq("bars_col56", 64'(cap56), 64'(32'hFFFFFFFF));

        // Gradient with three wait states per access.
        pattern_sel = 2'd2; ws_cfg = 3;
        push_seq(2'd2, 24'h0, NXF);
        run_seq("wait3", 1 + 5 * NXF + 1, 1'b1, 1'b0, NXF, 0);
        check_eq("wait3_stalls", 64'(stall_cycles), 64'(3 * NXF));
        ws_cfg = 0;

        // PPROW access never completes: timeout abort.
        pattern_sel = 2'd0; stall_ppr = 1'b1;
        push_seq(2'd0, 24'h0000FF, 1);
        run_seq("timeout", 1 + 2 + 1 + 255 + 1, 1'b0, 1'b1, 1, 0);
        check_eq("timeout_waits", 64'(stall_cycles), 64'(255));
        stall_ppr = 1'b0;

        // Wrong signature, and a start pulse mid-fill that must be ignored.
        pattern_sel = 2'd3; solid_colour = 24'h123456; m_prdata = 32'h1234_5678;
        push_seq(2'd3, 24'h123456, NXF);
        run_seq("badsig", 1 + 2 * NXF + 1, 1'b0, 1'b0, NXF, 100);
        m_prdata = 32'hDEAD_BEEF;

        // Slave error on the CONTROL write.
        slverr_ctrl = 1'b1;
        push_seq(2'd3, 24'h123456, 1);
        run_seq("slverr", 4, 1'b0, 1'b1, 1, 0);
        slverr_ctrl = 1'b0;

        // Reset asserted during FILL at row 1 col 10, then a clean restart.
        pattern_sel = 2'd2; sb_en = 1'b0;
        @(negedge pclk); #1;
        start = 1'b1;
        @(negedge pclk); #1;
        start = 1'b0;
        n = 0;
        while (!(m_psel && m_paddr == 18'h00828) && n < 1000) begin
            @(negedge pclk); #1;
            n++;
        end
        check_eq("midrst_reached", 64'({m_psel, m_paddr}), 64'({1'b1, 18'h00828}));
        presetn = 1'b0;
        #1;
        check_eq("midrst_idle", 64'({m_psel, m_penable, busy, done}), 64'(0));
        repeat (2) @(negedge pclk);
        #1;
        presetn = 1'b1; sb_en = 1'b1;
        push_seq(2'd2, 24'h0, NXF);
        run_seq("restart", 1 + 2 * NXF + 1, 1'b1, 1'b0, NXF, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
